// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: nibble size, FSM states and
// the step-counter width helper.
package sub_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Width of the nibble step counter; never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned width);
        int unsigned steps;
        steps = width / NIBBLE;
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/nibble_borrow_slice.sv
// Combinational 4-bit borrow-ripple subtractor: d = x - y - br_in, built from four
// single-bit full-subtractor stages.
module nibble_borrow_slice
    import sub_pkg::*;
(
    input  logic [NIBBLE-1:0] x,
    input  logic [NIBBLE-1:0] y,
    input  logic              br_in,
    output logic [NIBBLE-1:0] d,
    output logic              br_out
);

    logic br;

    // The borrow chain is a procedural variable so the ripple stays a single
    // combinational block instead of a self-referencing vector.
    always_comb begin
        br = br_in;
        d  = '0;
        for (int i = 0; i < NIBBLE; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        br_out = br;
    end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per clock, low nibble first,
// behind valid/ready handshakes. Define SUB_SIGNED_OVF_EN to build the signed overflow flag.
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned STEPS = WIDTH / NIBBLE;
    localparam int unsigned CW    = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (WIDTH < NIBBLE || (WIDTH % NIBBLE) != 0) begin : g_bad_width
            $error("nibble_serial_subtractor: WIDTH must be a nonzero multiple of 4");
        end
    endgenerate

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              br_q;
    logic [CW-1:0]     cnt_q;

    logic [NIBBLE-1:0] x;
    logic [NIBBLE-1:0] y;
    logic [NIBBLE-1:0] d;
    logic              br_next;

    assign x = a_q[NIBBLE*cnt_q +: NIBBLE];
    assign y = b_q[NIBBLE*cnt_q +: NIBBLE];

    nibble_borrow_slice u_slice (
        .x      (x),
        .y      (y),
        .br_in  (br_q),
        .d      (d),
        .br_out (br_next)
    );

    assign in_ready = (state == IDLE);

`ifdef SUB_SIGNED_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            br_q      <= 1'b0;
            cnt_q     <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        br_q  <= bin;
                        cnt_q <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    diff[NIBBLE*cnt_q +: NIBBLE] <= d;
                    br_q  <= br_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        bout      <= br_next;
`ifdef SUB_SIGNED_OVF_EN
                        // The top nibble is written this cycle, so its MSB is the result sign.
                        ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) & (d[NIBBLE-1] != a_q[WIDTH-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
